// File: rtl/plinko_histogram_if.sv
// Handshake bundle for plinko_histogram: drop input, readout stream and status.
// The master drives drops and commands, and the slave (the histogram) answers.
interface plinko_histogram_if #(
    parameter int ROWS  = 7,
    parameter int CNT_W = 5
);
    localparam int BINS  = ROWS + 1;
    localparam int LOC_W = ($clog2(BINS) > 1) ? $clog2(BINS) : 1;
    localparam int TOT_W = CNT_W + LOC_W;

    logic             drop_valid;
    logic [ROWS-1:0]  drop_path;
    logic             drop_ready;
    logic [LOC_W-1:0] ball_location;
    logic             clear;
    logic             rd_start;
    logic             rd_valid;
    logic             rd_ready;
    logic [LOC_W-1:0] rd_bin;
    logic [CNT_W-1:0] rd_count;
    logic             rd_last;
    logic [TOT_W-1:0] total_drops;
    logic             sat_flag;

    modport master (
        output drop_valid, drop_path, clear, rd_start, rd_ready,
        input  drop_ready, ball_location, rd_valid, rd_bin, rd_count, rd_last,
               total_drops, sat_flag
    );

    modport slave (
        input  drop_valid, drop_path, clear, rd_start, rd_ready,
        output drop_ready, ball_location, rd_valid, rd_bin, rd_count, rd_last,
               total_drops, sat_flag
    );
endinterface

// File: rtl/plinko_histogram.sv
// Plinko landing-bin histogram: counts drops per bin (popcount of the path),
// streams the bins out on request and clears them with a one-bin-per-cycle sweep.
module plinko_histogram #(
    parameter int ROWS  = 7,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic rst,
    plinko_histogram_if.slave bus
);
    localparam int BINS  = ROWS + 1;
    localparam int LOC_W = ($clog2(BINS) > 1) ? $clog2(BINS) : 1;
    localparam int TOT_W = CNT_W + LOC_W;
    localparam logic [LOC_W-1:0] LAST_BIN = LOC_W'(BINS - 1);

    typedef enum logic [1:0] {ACCEPT, DUMP, CLEAR} state_t;

    state_t           state_reg, state_next;
    logic [LOC_W-1:0] rd_ptr_reg;
    logic [LOC_W-1:0] clr_idx_reg;
    logic [LOC_W-1:0] loc;
    logic [TOT_W-1:0] total_reg;
    logic             sat_reg;
    logic [CNT_W-1:0] bin_val [BINS];
    logic [BINS-1:0]  bin_sat;
    logic             accept;
    logic             beat_done;

    always_comb begin
        loc = '0;
        for (int i = 0; i < ROWS; i++) begin
            loc = loc + LOC_W'(bus.drop_path[i]);
        end
    end

    // clear outranks a drop presented in the same cycle
    assign accept    = (state_reg == ACCEPT) && bus.drop_valid && !bus.clear;
    assign beat_done = (state_reg == DUMP) && bus.rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACCEPT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCEPT:  if (bus.rd_start) state_next = DUMP;
            DUMP:    if (beat_done && rd_ptr_reg == LAST_BIN) state_next = ACCEPT;
            CLEAR:   if (clr_idx_reg == LAST_BIN) state_next = ACCEPT;
            default: state_next = ACCEPT;
        endcase
        if (bus.clear) begin
            state_next = CLEAR;
        end
    end

    // Both indices wrap at LAST_BIN so they stay in range for odd bin counts
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            rd_ptr_reg  <= '0;
            clr_idx_reg <= '0;
        end else begin
            if (beat_done) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_BIN) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (state_reg == CLEAR) begin
                clr_idx_reg <= (clr_idx_reg == LAST_BIN) ? '0 : clr_idx_reg + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < BINS; gi++) begin : g_bin
        logic [CNT_W-1:0] cnt_reg;
        logic             hit;

        assign hit         = accept && (loc == LOC_W'(gi));
        assign bin_sat[gi] = hit && (&cnt_reg);
        assign bin_val[gi] = cnt_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (state_reg == CLEAR && clr_idx_reg == LOC_W'(gi)) begin
                cnt_reg <= '0;
            end else if (hit && !(&cnt_reg)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            total_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            if (accept) begin
                if (&total_reg) begin
                    sat_reg <= 1'b1;
                end else begin
                    total_reg <= total_reg + 1'b1;
                end
            end
            if (|bin_sat) begin
                sat_reg <= 1'b1;
            end
        end
    end

    assign bus.ball_location = loc;
    assign bus.drop_ready    = (state_reg == ACCEPT);
    assign bus.rd_valid      = (state_reg == DUMP);
    assign bus.rd_bin        = rd_ptr_reg;
    assign bus.rd_count      = (state_reg == DUMP) ? bin_val[rd_ptr_reg] : '0;
    assign bus.rd_last       = (state_reg == DUMP) && (rd_ptr_reg == LAST_BIN);
    assign bus.total_drops   = total_reg;
    assign bus.sat_flag      = sat_reg;
endmodule

// File: tb/tb_plinko_histogram.sv
// Bench for plinko_histogram: two instances (7 rows/5-bit and 4 rows/3-bit)
// driven by directed and random drops, checked against per-bin count arrays.
module tb_plinko_histogram;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    plinko_histogram_if #(.ROWS(7), .CNT_W(5)) ifa ();
    plinko_histogram_if #(.ROWS(4), .CNT_W(3)) ifb ();

    plinko_histogram #(.ROWS(7), .CNT_W(5)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
    plinko_histogram #(.ROWS(4), .CNT_W(3)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

    int vectors = 0;
    int miscompares = 0;

    int unsigned ma [8];
    int unsigned tot_a;
    bit          sat_a;
    int unsigned mb [5];
    int unsigned tot_b;
    bit          sat_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_a(input logic [6:0] p);
        int l;
        l = $countones(p);
        if (ma[l] == 31) sat_a = 1'b1; else ma[l]++;
        if (tot_a == 255) sat_a = 1'b1; else tot_a++;
    endtask

    task automatic model_b(input logic [3:0] p);
        int l;
        l = $countones(p);
        if (mb[l] == 7) sat_b = 1'b1; else mb[l]++;
        if (tot_b == 63) sat_b = 1'b1; else tot_b++;
    endtask

    task automatic zero_a();
        for (int i = 0; i < 8; i++) ma[i] = 0;
        tot_a = 0;
        sat_a = 1'b0;
    endtask

    task automatic zero_b();
        for (int i = 0; i < 5; i++) mb[i] = 0;
        tot_b = 0;
        sat_b = 1'b0;
    endtask

    task automatic drop_a(input logic [6:0] p, input bit v);
        ifa.drop_valid = v;
        ifa.drop_path  = p;
        #1;
        chk("a_ball_location", 32'(ifa.ball_location), $countones(p));
        @(posedge clk);
        #1;
        if (v) model_a(p);
        ifa.drop_valid = 1'b0;
    endtask

    task automatic drop_b(input logic [3:0] p, input bit v);
        ifb.drop_valid = v;
        ifb.drop_path  = p;
        #1;
        chk("b_ball_location", 32'(ifb.ball_location), $countones(p));
        @(posedge clk);
        #1;
        if (v) model_b(p);
        ifb.drop_valid = 1'b0;
    endtask

    // Full readout on instance A; a drop may ride along with rd_start
    task automatic dump_a(input bit toggle, input bit with_drop);
        int b;
        int cyc;
        bit rdy;
        logic [6:0] p;
        p = 7'($urandom);
        ifa.rd_start   = 1'b1;
        ifa.drop_valid = with_drop;
        ifa.drop_path  = p;
        tick();
        if (with_drop) model_a(p);
        ifa.rd_start   = 1'b0;
        b = 0;
        cyc = 0;
        while (b < 8 && cyc < 40) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            ifa.rd_ready   = rdy;
            ifa.drop_valid = 1'($urandom);
            ifa.drop_path  = 7'($urandom);
            chk("a_rd_valid", 32'(ifa.rd_valid), 1);
            chk("a_rd_bin", 32'(ifa.rd_bin), b);
            chk("a_rd_count", 32'(ifa.rd_count), ma[b]);
            chk("a_rd_last", 32'(ifa.rd_last), 32'(b == 7));
            chk("a_drop_ready_dump", 32'(ifa.drop_ready), 0);
            tick();
            cyc++;
            if (rdy) b++;
        end
        ifa.rd_ready   = 1'b0;
        ifa.drop_valid = 1'b0;
        chk("a_dump_cycles", cyc, toggle ? 15 : 8);
        chk("a_rd_valid_after", 32'(ifa.rd_valid), 0);
        chk("a_drop_ready_after", 32'(ifa.drop_ready), 1);
    endtask

    task automatic dump_b();
        int b;
        int cyc;
        ifb.rd_start = 1'b1;
        tick();
        ifb.rd_start = 1'b0;
        ifb.rd_ready = 1'b1;
        b = 0;
        cyc = 0;
        while (ifb.rd_valid && cyc < 20) begin
            chk("b_rd_bin", 32'(ifb.rd_bin), b);
            chk("b_rd_count", 32'(ifb.rd_count), (b < 5) ? mb[b] : 0);
            chk("b_rd_last", 32'(ifb.rd_last), 32'(b == 4));
            tick();
            cyc++;
            b++;
        end
        ifb.rd_ready = 1'b0;
        chk("b_dump_cycles", cyc, 5);
    endtask

    initial begin
        ifa.drop_valid = 0; ifa.drop_path = '0; ifa.clear = 0; ifa.rd_start = 0; ifa.rd_ready = 0;
        ifb.drop_valid = 0; ifb.drop_path = '0; ifb.clear = 0; ifb.rd_start = 0; ifb.rd_ready = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        zero_a();
        zero_b();
        tick();
        tick();
        rst_a = 1'b0;

        chk("a_rst_drop_ready", 32'(ifa.drop_ready), 1);
        chk("a_rst_rd_valid", 32'(ifa.rd_valid), 0);
        chk("a_rst_rd_bin", 32'(ifa.rd_bin), 0);
        chk("a_rst_rd_count", 32'(ifa.rd_count), 0);
        chk("a_rst_rd_last", 32'(ifa.rd_last), 0);
        chk("a_rst_total", 32'(ifa.total_drops), 0);
        chk("a_rst_sat", 32'(ifa.sat_flag), 0);

        // Three directed paths land in bins 0, 4 and 7
        drop_a(7'b0000000, 1'b1);
        drop_a(7'b1010101, 1'b1);
        drop_a(7'b1111111, 1'b1);
        chk("a_total_three", 32'(ifa.total_drops), 3);
        dump_a(1'b0, 1'b0);

        // Random drops, then a dump with back-pressure and a same-cycle drop
        repeat (25) drop_a(7'($urandom), 1'($urandom));
        chk("a_total_random", 32'(ifa.total_drops), tot_a);
        chk("a_sat_random", 32'(ifa.sat_flag), 32'(sat_a));
        dump_a(1'b1, 1'b1);
        chk("a_total_after_dump", 32'(ifa.total_drops), tot_a);

        // Abort a dump at beat 3 with clear, then sweep while drops and rd_start are ignored
        ifa.rd_start = 1'b1;
        tick();
        ifa.rd_start = 1'b0;
        ifa.rd_ready = 1'b1;
        repeat (3) tick();
        chk("a_beat3", 32'(ifa.rd_bin), 3);
        ifa.clear = 1'b1;
        tick();
        ifa.clear = 1'b0;
        ifa.rd_ready = 1'b0;
        zero_a();
        chk("a_clr_rd_valid", 32'(ifa.rd_valid), 0);
        chk("a_clr_rd_last", 32'(ifa.rd_last), 0);
        chk("a_clr_total", 32'(ifa.total_drops), 0);
        chk("a_clr_sat", 32'(ifa.sat_flag), 0);
        for (int i = 0; i < 8; i++) begin
            ifa.drop_valid = 1'b1;
            ifa.drop_path  = 7'($urandom);
            ifa.rd_start   = 1'b1;
            chk("a_clr_busy", 32'(ifa.drop_ready), 0);
            tick();
        end
        ifa.drop_valid = 1'b0;
        ifa.rd_start   = 1'b0;
        chk("a_clr_done_ready", 32'(ifa.drop_ready), 1);
        chk("a_clr_done_rd_valid", 32'(ifa.rd_valid), 0);
        dump_a(1'b0, 1'b0);

        // Saturate bin 1: sticky flag from the 32nd acceptance
        for (int i = 1; i <= 33; i++) begin
            drop_a(7'b0000001, 1'b1);
            chk("a_sat_step", 32'(ifa.sat_flag), 32'(sat_a));
        end
        chk("a_sat_total", 32'(ifa.total_drops), 33);
        dump_a(1'b0, 1'b0);

        // clear during CLEAR restarts the sweep from bin 0
        ifa.clear = 1'b1;
        tick();
        ifa.clear = 1'b0;
        repeat (3) tick();
        chk("a_restart_busy", 32'(ifa.drop_ready), 0);
        ifa.clear = 1'b1;
        tick();
        ifa.clear = 1'b0;
        zero_a();
        for (int i = 0; i < 8; i++) begin
            chk("a_restart_sweep", 32'(ifa.drop_ready), 0);
            tick();
        end
        chk("a_restart_done", 32'(ifa.drop_ready), 1);
        repeat (20) drop_a(7'($urandom), 1'($urandom));
        dump_a(1'b1, 1'b1);

        // Second instance: 5 bins, 3-bit counters, reset in the middle of a dump
        rst_b = 1'b0;
        chk("b_rst_drop_ready", 32'(ifb.drop_ready), 1);
        repeat (40) drop_b(4'($urandom), 1'($urandom));
        chk("b_total", 32'(ifb.total_drops), tot_b);
        chk("b_sat", 32'(ifb.sat_flag), 32'(sat_b));
        dump_b();
        ifb.rd_start = 1'b1;
        tick();
        ifb.rd_start = 1'b0;
        ifb.rd_ready = 1'b1;
        repeat (2) tick();
        rst_b = 1'b1;
        ifb.drop_valid = 1'b1;
        ifb.drop_path  = 4'b0011;
        tick();
        zero_b();
        chk("b_mid_rst_rd_valid", 32'(ifb.rd_valid), 0);
        chk("b_mid_rst_rd_bin", 32'(ifb.rd_bin), 0);
        chk("b_mid_rst_rd_count", 32'(ifb.rd_count), 0);
        chk("b_mid_rst_rd_last", 32'(ifb.rd_last), 0);
        chk("b_mid_rst_total", 32'(ifb.total_drops), 0);
        chk("b_mid_rst_sat", 32'(ifb.sat_flag), 0);
        chk("b_mid_rst_drop_ready", 32'(ifb.drop_ready), 1);
        rst_b = 1'b0;
        ifb.drop_valid = 1'b0;
        ifb.rd_ready = 1'b0;
        dump_b();
        chk("b_after_rd_valid", 32'(ifb.rd_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
